// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions for the SRAM adapter: channel opcodes,
// D-response record and the A-channel legality check.
package tl_ul_pkg;

  localparam int TL_SIZE_W   = 2;
  localparam int TL_SOURCE_W = 1;
  localparam int TL_DATA_W   = 32;
  localparam int TL_MASK_W   = TL_DATA_W / 8;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } d_opcode_e;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [TL_SIZE_W-1:0]   size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   denied;
    logic [TL_DATA_W-1:0]   data;
  } d_resp_t;

  // Known opcode, at most one word, naturally aligned, at least one lane.
  function automatic logic a_is_legal(input logic [2:0] opcode,
                                      input logic [TL_SIZE_W-1:0] size,
                                      input logic [1:0] addr_lo,
                                      input logic [TL_MASK_W-1:0] mask);
    logic op_ok;
    logic align_ok;
    op_ok = (opcode == PUT_FULL) || (opcode == PUT_PARTIAL) || (opcode == GET);
    case (size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = !addr_lo[0];
      2'd2:    align_ok = (addr_lo == 2'b00);
      default: align_ok = 1'b0;
    endcase
    return op_ok && align_ok && (|mask);
  endfunction

endpackage

// File: rtl/tl_resp_fifo2.sv
// Two-entry in-order FIFO of D-channel responses; head is read straight
// from the entry registers.
module tl_resp_fifo2
  import tl_ul_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    push,
  input  d_resp_t push_data,
  input  logic    pop,
  output d_resp_t head,
  output logic    empty
);

  d_resp_t    mem_q [2];
  d_resp_t    mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign mem_d[gi] = (push && (wr_ptr_q == 1'(gi))) ? push_data : mem_q[gi];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) mem_q[gi] <= '0;
      else          mem_q[gi] <= mem_d[gi];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/tl_ul_sram_adapter.sv
// TileLink-UL slave terminus: single-beat A requests drive a 1-cycle SRAM,
// acks return through a stage register and a 2-entry response FIFO.
module tl_ul_sram_adapter
  import tl_ul_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int SIZE_W   = 2,
  parameter int SOURCE_W = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [DATA_W/8-1:0] a_mask,
  input  logic [DATA_W-1:0]   a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [SIZE_W-1:0]   d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [DATA_W-1:0]   d_data,
  output logic                sram_req,
  output logic                sram_we,
  output logic [ADDR_W-3:0]   sram_addr,
  output logic [DATA_W/8-1:0] sram_wmask,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  logic                a_ready_q, a_ready_d;
  logic [1:0]          credit_q, credit_d;
  logic                st_valid_q, st_valid_d;
  logic                st_is_get_q, st_is_get_d;
  logic [SIZE_W-1:0]   st_size_q, st_size_d;
  logic [SOURCE_W-1:0] st_source_q, st_source_d;
  logic                st_denied_q, st_denied_d;

  logic    accept, legal, deq;
  logic    fifo_push, fifo_pop, fifo_empty;
  d_resp_t stage_resp, fifo_head, d_resp;
  logic    unused_a_param;

  assign unused_a_param = ^a_param;

  always_comb begin
    legal  = a_is_legal(a_opcode, a_size, a_address[1:0], a_mask);
    accept = a_valid && a_ready_q;

    sram_req   = accept && legal;
    sram_we    = (a_opcode != GET);
    sram_wmask = (a_opcode == PUT_FULL) ? '1 : a_mask;
    sram_addr  = a_address[ADDR_W-1:2];
    sram_wdata = a_data;

    // sram_rdata is only valid this one cycle, so it is folded in here.
    stage_resp.opcode = st_is_get_q ? ACK_DATA : ACK;
    stage_resp.size   = st_size_q;
    stage_resp.source = st_source_q;
    stage_resp.denied = st_denied_q;
    stage_resp.data   = (st_is_get_q && !st_denied_q) ? sram_rdata : '0;

    // An empty FIFO lets the stage present directly; if taken, skip the push.
    d_valid   = st_valid_q || !fifo_empty;
    d_resp    = fifo_empty ? stage_resp : fifo_head;
    deq       = d_valid && d_ready;
    fifo_pop  = !fifo_empty && d_ready;
    fifo_push = st_valid_q && !(fifo_empty && d_ready);

    credit_d  = credit_q + 2'(accept) - 2'(deq);
    a_ready_d = (credit_d < 2'd2);

    st_valid_d  = accept;
    st_is_get_d = (a_opcode == GET);
    st_size_d   = a_size;
    st_source_d = a_source;
    st_denied_d = !legal;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_ready_q   <= 1'b0;
      credit_q    <= 2'd0;
      st_valid_q  <= 1'b0;
      st_is_get_q <= 1'b0;
      st_size_q   <= '0;
      st_source_q <= '0;
      st_denied_q <= 1'b0;
    end else begin
      a_ready_q   <= a_ready_d;
      credit_q    <= credit_d;
      st_valid_q  <= st_valid_d;
      st_is_get_q <= st_is_get_d;
      st_size_q   <= st_size_d;
      st_source_q <= st_source_d;
      st_denied_q <= st_denied_d;
    end
  end

  tl_resp_fifo2 u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (stage_resp),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign a_ready  = a_ready_q;
  assign d_opcode = d_resp.opcode;
  assign d_param  = 2'b00;
  assign d_size   = d_resp.size;
  assign d_source = d_resp.source;
  assign d_denied = d_resp.denied;
  assign d_data   = d_resp.data;

endmodule
